fft8_sched: RTL and testbench

Sequencer for the 8-point radix-2 DIT FFT. It accepts 8 complex samples over a valid/ready stream and stores them in bit-reversed order in an internal 8-entry buffer. It then drives a shared external twiddle-multiply-plus-butterfly pipe through 3 stages × 4 butterflies, writes each result back in place, and streams the 8 results out in natural order. It sits between the sample source and the butterfly datapath, which holds no control of its own.

---
 rtl/fft8_pkg.sv | 43 ++++
 rtl/fft8_wb_tracker.sv | 47 ++++
 rtl/fft8_sched.sv | 261 ++++++++++++++++++++++++++
 tb/tb_fft8_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared types, sizes, bit-reversal helper and the per-stage butterfly
// schedule (top/bottom buffer addresses and twiddle index per [stage][b])
// for the 8-point radix-2 DIT FFT sequencer.
package fft8_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_UNLOAD = 2'd3
    } state_e;

    localparam int N      = 8;
    localparam int STAGES = 3;
    localparam int BFLY   = 4;

    // Top (A) operand address per [stage][butterfly]
    localparam logic [2:0] TOP_TBL [0:2][0:3] = '{
        '{3'd0, 3'd2, 3'd4, 3'd6},
        '{3'd0, 3'd1, 3'd4, 3'd5},
        '{3'd0, 3'd1, 3'd2, 3'd3}
    };

    // Bottom (B) operand address per [stage][butterfly]
    localparam logic [2:0] BOT_TBL [0:2][0:3] = '{
        '{3'd1, 3'd3, 3'd5, 3'd7},
        '{3'd2, 3'd3, 3'd6, 3'd7},
        '{3'd4, 3'd5, 3'd6, 3'd7}
    };

    // Twiddle exponent k of W8^k applied to B per [stage][butterfly]
    localparam logic [1:0] TW_TBL [0:2][0:3] = '{
        '{2'd0, 2'd0, 2'd0, 2'd0},
        '{2'd0, 2'd2, 2'd0, 2'd2},
        '{2'd0, 2'd1, 2'd2, 2'd3}
    };

    // Reverse the three index bits (natural order <-> DIT input order)
    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        bitrev3 = {n[0], n[1], n[2]};
    endfunction

endpackage

// File: rtl/fft8_wb_tracker.sv
// Write-back address tracker: carries {valid, top, bottom} of each issued
// butterfly alongside the external pipe so the result can be written back
// in place when it emerges PIPE_LAT cycles later.
module fft8_wb_tracker
    import fft8_pkg::*;
#(
    parameter int PIPE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [2:0] i_top,
    input  logic [2:0] i_bot,
    output logic       o_valid,
    output logic [2:0] o_top,
    output logic [2:0] o_bot
);

    logic       r_valid [PIPE_LAT];
    logic [2:0] r_top   [PIPE_LAT];
    logic [2:0] r_bot   [PIPE_LAT];

    // Shift issued addresses one slot per cycle; reset drops in-flight entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_valid[i] <= 1'b0;
                r_top[i]   <= 3'd0;
                r_bot[i]   <= 3'd0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_top[0]   <= i_top;
            r_bot[0]   <= i_bot;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_top[i]   <= r_top[i-1];
                r_bot[i]   <= r_bot[i-1];
            end
        end
    end

    assign o_valid = r_valid[PIPE_LAT-1];
    assign o_top   = r_top[PIPE_LAT-1];
    assign o_bot   = r_bot[PIPE_LAT-1];

endmodule

// File: rtl/fft8_sched.sv
// 8-point radix-2 DIT FFT sequencer: loads samples bit-reversed, drives an
// external twiddle+butterfly pipe for 3 stages x 4 butterflies with in-place
// write-back, then streams X[0..7] out in natural order.
module fft8_sched
    import fft8_pkg::*;
#(
    parameter int W        = 16,
    parameter int PIPE_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_last,
    output logic         busy,
    output logic         bf_valid,
    output logic [W-1:0] bf_ar1,
    output logic [W-1:0] bf_ai1,
    output logic [W-1:0] bf_ar2,
    output logic [W-1:0] bf_ai2,
    output logic [1:0]   bf_tw,
    input  logic [W-1:0] bf_cr1,
    input  logic [W-1:0] bf_ci1,
    input  logic [W-1:0] bf_cr2,
    input  logic [W-1:0] bf_ci2
);

    localparam int             DCW        = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PIPE_LAT - 1);

    state_e         r_state, w_state_nxt;
    logic [2:0]     r_in_cnt, w_in_cnt_nxt;
    logic [1:0]     r_stage, w_stage_nxt;
    logic [1:0]     r_bfly, w_bfly_nxt;
    logic [DCW-1:0] r_drain, w_drain_nxt;
    logic [2:0]     r_out_k, w_out_k_nxt;

    logic [W-1:0]   r_buf_re [N];
    logic [W-1:0]   r_buf_im [N];
    logic [W-1:0]   w_fwd_re [N];
    logic [W-1:0]   w_fwd_im [N];

    logic           w_wb_valid;
    logic [2:0]     w_wb_top, w_wb_bot;
    logic [2:0]     w_top_nxt, w_bot_nxt;
    logic [1:0]     w_tw_nxt;
    logic           w_in_fire, w_out_fire;

    logic           r_in_ready, r_out_valid, r_out_last, r_busy, r_bf_valid;
    logic [W-1:0]   r_out_re, r_out_im;
    logic [W-1:0]   r_bf_ar1, r_bf_ai1, r_bf_ar2, r_bf_ai2;
    logic [1:0]     r_bf_tw;
    logic [2:0]     r_bf_top, r_bf_bot;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    fft8_wb_tracker #(
        .PIPE_LAT (PIPE_LAT)
    ) u_wb_tracker (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_bf_valid),
        .i_top   (r_bf_top),
        .i_bot   (r_bf_bot),
        .o_valid (w_wb_valid),
        .o_top   (w_wb_top),
        .o_bot   (w_wb_bot)
    );

    // Next-state and counter update for LOAD/RUN/DRAIN/UNLOAD sequencing
    always_comb begin
        w_state_nxt  = r_state;
        w_in_cnt_nxt = r_in_cnt;
        w_stage_nxt  = r_stage;
        w_bfly_nxt   = r_bfly;
        w_drain_nxt  = r_drain;
        w_out_k_nxt  = r_out_k;
        case (r_state)
            ST_LOAD: begin
                if (w_in_fire) begin
                    if (r_in_cnt == 3'(N - 1)) begin
                        w_state_nxt  = ST_RUN;
                        w_in_cnt_nxt = 3'd0;
                        w_stage_nxt  = 2'd0;
                        w_bfly_nxt   = 2'd0;
                    end else begin
                        w_in_cnt_nxt = r_in_cnt + 3'd1;
                    end
                end else begin
                    w_in_cnt_nxt = r_in_cnt;
                end
            end
            ST_RUN: begin
                if (r_bfly == 2'(BFLY - 1)) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = '0;
                end else begin
                    w_bfly_nxt = r_bfly + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    if (r_stage == 2'(STAGES - 1)) begin
                        w_state_nxt = ST_UNLOAD;
                        w_out_k_nxt = 3'd0;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_stage_nxt = r_stage + 2'd1;
                        w_bfly_nxt  = 2'd0;
                    end
                end else begin
                    w_drain_nxt = r_drain + DCW'(1);
                end
            end
            ST_UNLOAD: begin
                if (w_out_fire) begin
                    if (r_out_k == 3'(N - 1)) begin
                        w_state_nxt = ST_LOAD;
                        w_out_k_nxt = 3'd0;
                    end else begin
                        w_out_k_nxt = r_out_k + 3'd1;
                    end
                end else begin
                    w_out_k_nxt = r_out_k;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // Schedule lookup for the butterfly that will be on the bf_* outputs next cycle
    always_comb begin
        w_top_nxt = TOP_TBL[w_stage_nxt][w_bfly_nxt];
        w_bot_nxt = BOT_TBL[w_stage_nxt][w_bfly_nxt];
        w_tw_nxt  = TW_TBL[w_stage_nxt][w_bfly_nxt];
    end

    // Buffer view with this cycle's write-back applied, so reads never see stale data
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (w_wb_valid && (w_wb_top == 3'(i))) begin
                w_fwd_re[i] = bf_cr1;
                w_fwd_im[i] = bf_ci1;
            end else if (w_wb_valid && (w_wb_bot == 3'(i))) begin
                w_fwd_re[i] = bf_cr2;
                w_fwd_im[i] = bf_ci2;
            end else begin
                w_fwd_re[i] = r_buf_re[i];
                w_fwd_im[i] = r_buf_im[i];
            end
        end
    end

    // Sample buffer: bit-reversed load, otherwise in-place butterfly write-back
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (w_in_fire && (bitrev3(r_in_cnt) == 3'(i))) begin
                r_buf_re[i] <= in_re;
                r_buf_im[i] <= in_im;
            end else begin
                r_buf_re[i] <= w_fwd_re[i];
                r_buf_im[i] <= w_fwd_im[i];
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_LOAD;
            r_in_cnt <= 3'd0;
            r_stage  <= 2'd0;
            r_bfly   <= 2'd0;
            r_drain  <= '0;
            r_out_k  <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_in_cnt <= w_in_cnt_nxt;
            r_stage  <= w_stage_nxt;
            r_bfly   <= w_bfly_nxt;
            r_drain  <= w_drain_nxt;
            r_out_k  <= w_out_k_nxt;
        end
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_bf_valid  <= 1'b0;
            r_bf_tw     <= 2'd0;
            r_bf_top    <= 3'd0;
            r_bf_bot    <= 3'd0;
            r_bf_ar1    <= '0;
            r_bf_ai1    <= '0;
            r_bf_ar2    <= '0;
            r_bf_ai2    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            r_in_ready <= (w_state_nxt == ST_LOAD);
            r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            if (w_state_nxt == ST_RUN) begin
                r_bf_valid <= 1'b1;
                r_bf_tw    <= w_tw_nxt;
                r_bf_top   <= w_top_nxt;
                r_bf_bot   <= w_bot_nxt;
                r_bf_ar1   <= w_fwd_re[w_top_nxt];
                r_bf_ai1   <= w_fwd_im[w_top_nxt];
                r_bf_ar2   <= w_fwd_re[w_bot_nxt];
                r_bf_ai2   <= w_fwd_im[w_bot_nxt];
            end else begin
                r_bf_valid <= 1'b0;
                r_bf_tw    <= 2'd0;
                r_bf_top   <= 3'd0;
                r_bf_bot   <= 3'd0;
                r_bf_ar1   <= '0;
                r_bf_ai1   <= '0;
                r_bf_ar2   <= '0;
                r_bf_ai2   <= '0;
            end
            if (w_state_nxt == ST_UNLOAD) begin
                r_out_valid <= 1'b1;
                r_out_last  <= (w_out_k_nxt == 3'(N - 1));
                r_out_re    <= w_fwd_re[w_out_k_nxt];
                r_out_im    <= w_fwd_im[w_out_k_nxt];
            end else begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_out_re    <= '0;
                r_out_im    <= '0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign bf_valid  = r_bf_valid;
    assign bf_tw     = r_bf_tw;
    assign bf_ar1    = r_bf_ar1;
    assign bf_ai1    = r_bf_ai1;
    assign bf_ar2    = r_bf_ar2;
    assign bf_ai2    = r_bf_ai2;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;

endmodule

// File: tb/tb_fft8_sched.sv
// Directed self-checking bench for fft8_sched with a behavioural
// twiddle+butterfly pipe of depth PL and a software DIT golden model.
module tb_fft8_sched;

    localparam int W  = 16;
    localparam int PL = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_re, out_im;
    logic         out_last, busy, bf_valid;
    logic [W-1:0] bf_ar1, bf_ai1, bf_ar2, bf_ai2;
    logic [1:0]   bf_tw;
    logic [W-1:0] bf_cr1, bf_ci1, bf_cr2, bf_ci2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    fft8_sched #(.W(W), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_last(out_last), .busy(busy), .bf_valid(bf_valid),
        .bf_ar1(bf_ar1), .bf_ai1(bf_ai1), .bf_ar2(bf_ar2), .bf_ai2(bf_ai2), .bf_tw(bf_tw),
        .bf_cr1(bf_cr1), .bf_ci1(bf_ci1), .bf_cr2(bf_cr2), .bf_ci2(bf_ci2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-point twiddle multiply (1/sqrt2 ~ 181/256) followed by the butterfly
    function automatic logic [4*W-1:0] bfly_f(input logic [W-1:0] ar, ai, br, bi,
                                              input logic [1:0] tw);
        int a_r, a_i, b_r, b_i, t_r, t_i;
        a_r = $signed(ar); a_i = $signed(ai);
        b_r = $signed(br); b_i = $signed(bi);
        case (tw)
            2'd0:    begin t_r = b_r; t_i = b_i; end
            2'd1:    begin t_r = (181 * (b_r + b_i)) >>> 8; t_i = (181 * (b_i - b_r)) >>> 8; end
            2'd2:    begin t_r = b_i; t_i = -b_r; end
            default: begin t_r = (181 * (b_i - b_r)) >>> 8; t_i = (-181 * (b_r + b_i)) >>> 8; end
        endcase
        return {W'(a_r + t_r), W'(a_i + t_i), W'(a_r - t_r), W'(a_i - t_i)};
    endfunction

    // External datapath: PL-deep registered twiddle+butterfly
    logic [4*W-1:0] pipe_q [PL];
    always @(posedge clk) begin
        pipe_q[0] <= bfly_f(bf_ar1, bf_ai1, bf_ar2, bf_ai2, bf_tw);
        for (int i = 1; i < PL; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign {bf_cr1, bf_ci1, bf_cr2, bf_ci2} = pipe_q[PL-1];

    // Golden model state and expected issue sequence
    logic [W-1:0] g_re [4][8];
    logic [W-1:0] g_im [4][8];
    logic [1:0]   e_tw  [12];
    logic [W-1:0] e_ar1 [12], e_ai1 [12], e_ar2 [12], e_ai2 [12];

    // Observations
    logic [W-1:0] rx_re [8], rx_im [8];
    logic         rx_last [8];
    int           iss_cyc [16];
    logic [1:0]   iss_tw  [16];
    logic [W-1:0] iss_ar1 [16], iss_ai1 [16], iss_ar2 [16], iss_ai2 [16];
    int n_iss, n_rx, hs_cyc, first_out_cyc, hold_viol, inready_viol;

    logic [W-1:0] xr [8], xi [8];

    task automatic golden();
        int idx, half, span, t, b;
        logic [2:0] nb;
        logic [4*W-1:0] res;
        for (int n = 0; n < 8; n++) begin
            nb = 3'(n);
            g_re[0][{nb[0], nb[1], nb[2]}] = xr[n];
            g_im[0][{nb[0], nb[1], nb[2]}] = xi[n];
        end
        idx = 0;
        for (int s = 0; s < 3; s++) begin
            half = 1 << s;
            span = 2 * half;
            for (int st = 0; st < 8; st += span) begin
                for (int j = 0; j < half; j++) begin
                    t = st + j;
                    b = t + half;
                    e_tw[idx]  = 2'(j * (8 / span));
                    e_ar1[idx] = g_re[s][t]; e_ai1[idx] = g_im[s][t];
                    e_ar2[idx] = g_re[s][b]; e_ai2[idx] = g_im[s][b];
                    res = bfly_f(g_re[s][t], g_im[s][t], g_re[s][b], g_im[s][b], e_tw[idx]);
                    g_re[s+1][t] = res[4*W-1 -: W]; g_im[s+1][t] = res[3*W-1 -: W];
                    g_re[s+1][b] = res[2*W-1 -: W]; g_im[s+1][b] = res[W-1 -: W];
                    idx++;
                end
            end
        end
    endtask

    task automatic random_frame();
        for (int n = 0; n < 8; n++) begin
            xr[n] = W'($urandom_range(0, 4095)) - 16'd2048;
            xi[n] = W'($urandom_range(0, 4095)) - 16'd2048;
        end
    endtask

    // Drive 8 samples; ends at the negedge of the first RUN cycle
    task automatic send_frame();
        int g;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            in_valid = 1'b1; in_re = xr[n]; in_im = xi[n];
            g = 0;
            while (in_ready !== 1'b1 && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) begin
                checks++; failures++;
                $display("FAIL send_timeout sample=%0d in_ready=%b", n, in_ready);
            end
            hs_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Observe issues and collect 8 outputs; ends at negedge of the last accept cycle
    task automatic collect(input bit rand_ready);
        int g;
        logic r, p_last;
        logic [W-1:0] p_re, p_im;
        bit prev_stall;
        n_iss = 0; n_rx = 0; first_out_cyc = -1; hold_viol = 0; inready_viol = 0;
        prev_stall = 1'b0; p_re = '0; p_im = '0; p_last = 1'b0; g = 0;
        while (n_rx < 8 && g < 500) begin
            if (in_ready !== 1'b0) inready_viol++;
            if (bf_valid === 1'b1 && n_iss < 16) begin
                iss_cyc[n_iss] = cyc; iss_tw[n_iss] = bf_tw;
                iss_ar1[n_iss] = bf_ar1; iss_ai1[n_iss] = bf_ai1;
                iss_ar2[n_iss] = bf_ar2; iss_ai2[n_iss] = bf_ai2;
                n_iss++;
            end
            if (prev_stall && (out_valid !== 1'b1 || out_re !== p_re ||
                               out_im !== p_im || out_last !== p_last)) hold_viol++;
            if (out_valid === 1'b1 && first_out_cyc < 0) first_out_cyc = cyc;
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (out_valid === 1'b1 && r) begin
                rx_re[n_rx] = out_re; rx_im[n_rx] = out_im; rx_last[n_rx] = out_last;
                n_rx++;
            end
            prev_stall = (out_valid === 1'b1) && !r;
            p_re = out_re; p_im = out_im; p_last = out_last;
            @(negedge clk);
            g++;
        end
        out_ready = 1'b0;
        checks++;
        if (n_rx !== 8) begin
            failures++;
            $display("FAIL collect_count got=%0d exp=8", n_rx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bf_valid !== 1'b0) begin failures++; $display("FAIL reset_bf_valid got=%b exp=0", bf_valid); end
        checks++; if (bf_tw !== 2'd0) begin failures++; $display("FAIL reset_bf_tw got=%0d exp=0", bf_tw); end
        checks++;
        if ({bf_ar1, bf_ai1, bf_ar2, bf_ai2, out_re, out_im} !== {(6*W){1'b0}}) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {bf_ar1, bf_ai1, bf_ar2, bf_ai2, out_re, out_im});
        end
    endtask

    task automatic test_impulse();
        for (int n = 0; n < 8; n++) begin xr[n] = '0; xi[n] = '0; end
        xr[0] = 16'd100;
        send_frame();
        collect(1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rx_re[k] !== 16'd100 || rx_im[k] !== 16'd0 || rx_last[k] !== (k == 7)) begin
                failures++;
                $display("FAIL impulse_X%0d got=(%0d,%0d,last=%b) exp=(100,0,last=%b)",
                         k, $signed(rx_re[k]), $signed(rx_im[k]), rx_last[k], k == 7);
            end
        end
    endtask

    task automatic test_back_to_back_dc();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        for (int n = 0; n < 8; n++) begin xr[n] = 16'd10; xi[n] = '0; end
        send_frame();
        collect(1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rx_re[k] !== ((k == 0) ? 16'd80 : 16'd0) || rx_im[k] !== 16'd0) begin
                failures++;
                $display("FAIL dc_X%0d got=(%0d,%0d) exp=(%0d,0)", k, $signed(rx_re[k]),
                         $signed(rx_im[k]), (k == 0) ? 80 : 0);
            end
        end
    endtask

    task automatic test_alternating();
        logic [1:0] twe [12];
        twe = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int n = 0; n < 8; n++) begin xr[n] = (n % 2 == 0) ? 16'd10 : 16'hFFF6; xi[n] = '0; end
        send_frame();
        collect(1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rx_re[k] !== ((k == 4) ? 16'd80 : 16'd0) || rx_im[k] !== 16'd0) begin
                failures++;
                $display("FAIL alt_X%0d got=(%0d,%0d) exp=(%0d,0)", k, $signed(rx_re[k]),
                         $signed(rx_im[k]), (k == 4) ? 80 : 0);
            end
        end
        checks++;
        if (n_iss !== 12) begin failures++; $display("FAIL alt_issue_count got=%0d exp=12", n_iss); end
        for (int i = 0; i < 12 && i < n_iss; i++) begin
            checks++;
            if (iss_tw[i] !== twe[i]) begin
                failures++; $display("FAIL alt_tw_%0d got=%0d exp=%0d", i, iss_tw[i], twe[i]);
            end
        end
    endtask

    task automatic test_latency();
        random_frame();
        golden();
        send_frame();
        collect(1'b0);
        checks++;
        if (first_out_cyc - hs_cyc !== 1 + 3 * (4 + PL)) begin
            failures++;
            $display("FAIL latency got=%0d exp=%0d", first_out_cyc - hs_cyc, 1 + 3 * (4 + PL));
        end
        checks++;
        if (n_iss !== 12) begin failures++; $display("FAIL lat_issue_count got=%0d exp=12", n_iss); end
        for (int i = 0; i < 12 && i < n_iss; i++) begin
            checks++;
            if (iss_cyc[i] - hs_cyc !== 1 + (i / 4) * (4 + PL) + (i % 4)) begin
                failures++;
                $display("FAIL lat_issue_cycle_%0d got=%0d exp=%0d", i, iss_cyc[i] - hs_cyc,
                         1 + (i / 4) * (4 + PL) + (i % 4));
            end
            checks++;
            if (iss_tw[i] !== e_tw[i] || iss_ar1[i] !== e_ar1[i] || iss_ai1[i] !== e_ai1[i] ||
                iss_ar2[i] !== e_ar2[i] || iss_ai2[i] !== e_ai2[i]) begin
                failures++;
                $display("FAIL lat_operands_%0d got=%0d:%h %h %h %h exp=%0d:%h %h %h %h", i,
                         iss_tw[i], iss_ar1[i], iss_ai1[i], iss_ar2[i], iss_ai2[i],
                         e_tw[i], e_ar1[i], e_ai1[i], e_ar2[i], e_ai2[i]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rx_re[k] !== g_re[3][k] || rx_im[k] !== g_im[3][k]) begin
                failures++;
                $display("FAIL lat_X%0d got=(%h,%h) exp=(%h,%h)", k, rx_re[k], rx_im[k],
                         g_re[3][k], g_im[3][k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        random_frame();
        golden();
        send_frame();
        collect(1'b1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rx_re[k] !== g_re[3][k] || rx_im[k] !== g_im[3][k] || rx_last[k] !== (k == 7)) begin
                failures++;
                $display("FAIL bp_X%0d got=(%h,%h,last=%b) exp=(%h,%h,last=%b)", k, rx_re[k],
                         rx_im[k], rx_last[k], g_re[3][k], g_im[3][k], k == 7);
            end
        end
        checks++;
        if (hold_viol !== 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
        checks++;
        if (inready_viol !== 0) begin failures++; $display("FAIL bp_in_ready got=%0d exp=0", inready_viol); end
    endtask

    task automatic test_reset_mid();
        random_frame();
        send_frame();
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bf_valid !== 1'b1) begin
            failures++; $display("FAIL mid_busy got=%b%b exp=11", busy, bf_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        checks++; if (bf_valid !== 1'b0) begin failures++; $display("FAIL mid_bf_valid got=%b exp=0", bf_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
        for (int n = 0; n < 8; n++) begin xr[n] = 16'd10; xi[n] = '0; end
        send_frame();
        collect(1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rx_re[k] !== ((k == 0) ? 16'd80 : 16'd0) || rx_im[k] !== 16'd0) begin
                failures++;
                $display("FAIL mid_dc_X%0d got=(%0d,%0d) exp=(%0d,0)", k, $signed(rx_re[k]),
                         $signed(rx_im[k]), (k == 0) ? 80 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_back_to_back_dc();
        test_alternating();
        test_latency();
        test_back_pressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
